// File: rtl/conv_window_mac_if.sv
// Handshake bundle for conv_window_mac: kernel load, pixel stream in, result stream out.
// master drives the weight/pixel inputs and out_ready; slave is the MAC engine.
interface conv_window_mac_if #(
    parameter int DATA_W = 8,
    parameter int OUT_W  = 8
);
    logic              w_start;
    logic              w_valid;
    logic [DATA_W-1:0] w_data;
    logic              w_loaded;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [OUT_W-1:0]  out_data;
    logic              busy;

    modport master (
        output w_start, w_valid, w_data, in_valid, in_data, out_ready,
        input  w_loaded, in_ready, out_valid, out_data, busy
    );

    modport slave (
        input  w_start, w_valid, w_data, in_valid, in_data, out_ready,
        output w_loaded, in_ready, out_valid, out_data, busy
    );
endinterface

// File: rtl/conv_window_mac.sv
// Streaming K*K multiply-accumulate for one output pixel: signed kernel x unsigned pixels,
// followed by arithmetic shift, optional ReLU and saturation to OUT_W bits.
module conv_window_mac #(
    parameter int DATA_W = 8,
    parameter int K      = 3,
    parameter int ACC_W  = 24,
    parameter int OUT_W  = 8,
    parameter int SHIFT  = 0,
    parameter int RELU   = 0
) (
    input logic               clk,
    input logic               rst,
    conv_window_mac_if.slave  bus
);
    localparam int TAPS  = K * K;
    localparam int CNT_W = (TAPS > 1) ? $clog2(TAPS) : 1;
    localparam logic [CNT_W-1:0] LAST_TAP = CNT_W'(TAPS - 1);

    // Clamp bounds expressed at accumulator width so the compare is a plain signed one.
    localparam logic signed [ACC_W-1:0] SAT_HI =
        ACC_W'((RELU != 0) ? ((1 << OUT_W) - 1) : ((1 << (OUT_W - 1)) - 1));
    localparam logic signed [ACC_W-1:0] SAT_LO =
        ACC_W'((RELU != 0) ? 0 : -(1 << (OUT_W - 1)));

    typedef enum logic [1:0] {IDLE, LOADW, ACC, OUT} state_t;

    state_t                     state, state_nxt;
    logic signed [ACC_W-1:0]    acc;
    logic [CNT_W-1:0]           tap_cnt;
    logic                       w_loaded_q;
    logic [OUT_W-1:0]           out_q;
    logic [TAPS-1:0][DATA_W-1:0] weight;

    logic                       in_rdy;
    logic                       pix_acc;
    logic                       w_wr;
    logic                       last_tap;
    logic [DATA_W-1:0]          w_sel;
    logic signed [ACC_W-1:0]    w_ext;
    logic signed [ACC_W-1:0]    px_ext;
    logic signed [ACC_W-1:0]    prod;
    logic signed [ACC_W-1:0]    acc_base;
    logic signed [ACC_W-1:0]    acc_sum;
    logic signed [ACC_W-1:0]    shifted;
    logic signed [ACC_W-1:0]    sat_val;
    logic [OUT_W-1:0]           out_nxt;

    // w_start has priority over a pixel offered in the same IDLE cycle.
    assign in_rdy   = (state == ACC) || (state == IDLE && w_loaded_q && !bus.w_start);
    assign pix_acc  = bus.in_valid && in_rdy;
    assign w_wr     = (state == LOADW) && bus.w_valid;
    assign last_tap = (tap_cnt == LAST_TAP);

    for (genvar t = 0; t < TAPS; t++) begin : g_tap
        logic [DATA_W-1:0] w_q;
        always_ff @(posedge clk) begin
            if (rst)
                w_q <= '0;
            else if (w_wr && tap_cnt == CNT_W'(t))
                w_q <= bus.w_data;
        end
        assign weight[t] = w_q;
    end

    assign w_sel    = weight[tap_cnt];
    assign w_ext    = ACC_W'($signed(w_sel));
    assign px_ext   = {{(ACC_W-DATA_W){1'b0}}, bus.in_data};
    assign prod     = w_ext * px_ext;
    // The first tap of a window is taken from IDLE, so it starts from zero rather than acc.
    assign acc_base = (state == IDLE) ? '0 : acc;
    assign acc_sum  = acc_base + prod;
    assign shifted  = acc_sum >>> SHIFT;

    always_comb begin
        sat_val = shifted;
        if (shifted > SAT_HI)
            sat_val = SAT_HI;
        else if (shifted < SAT_LO)
            sat_val = SAT_LO;
    end

    assign out_nxt = sat_val[OUT_W-1:0];

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (bus.w_start)
                    state_nxt = LOADW;
                else if (pix_acc)
                    state_nxt = last_tap ? OUT : ACC;
            end
            LOADW: begin
                if (bus.w_valid && last_tap)
                    state_nxt = IDLE;
            end
            ACC: begin
                if (pix_acc && last_tap)
                    state_nxt = OUT;
            end
            OUT: begin
                if (bus.out_ready)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            acc        <= '0;
            tap_cnt    <= '0;
            w_loaded_q <= 1'b0;
            out_q      <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (bus.w_start) begin
                        tap_cnt <= '0;
                    end else if (pix_acc) begin
                        acc <= acc_sum;
                        if (last_tap) begin
                            tap_cnt <= '0;
                            out_q   <= out_nxt;
                        end else begin
                            tap_cnt <= CNT_W'(1);
                        end
                    end
                end
                LOADW: begin
                    if (bus.w_valid) begin
                        if (last_tap) begin
                            tap_cnt    <= '0;
                            w_loaded_q <= 1'b1;
                        end else begin
                            tap_cnt <= tap_cnt + CNT_W'(1);
                        end
                    end
                end
                ACC: begin
                    if (pix_acc) begin
                        acc <= acc_sum;
                        if (last_tap) begin
                            tap_cnt <= '0;
                            out_q   <= out_nxt;
                        end else begin
                            tap_cnt <= tap_cnt + CNT_W'(1);
                        end
                    end
                end
                OUT: begin
                    if (bus.out_ready) begin
                        acc     <= '0;
                        tap_cnt <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.w_loaded  = w_loaded_q;
    assign bus.in_ready  = in_rdy;
    assign bus.out_valid = (state == OUT);
    assign bus.out_data  = out_q;
    assign bus.busy      = (state != IDLE);
endmodule

// File: tb/tb_conv_window_mac.sv
// Scoreboard bench: three engines (plain, ReLU, SHIFT=2) share one stimulus stream and are
// each compared against a plain-arithmetic convolution model.
module tb_conv_window_mac;
    logic clk;
    logic rst;

    conv_window_mac_if #(.DATA_W(8), .OUT_W(8)) ia ();
    conv_window_mac_if #(.DATA_W(8), .OUT_W(8)) ib ();
    conv_window_mac_if #(.DATA_W(8), .OUT_W(8)) ic ();

    conv_window_mac #(.SHIFT(0), .RELU(0)) dut_a (.clk(clk), .rst(rst), .bus(ia.slave));
    conv_window_mac #(.SHIFT(0), .RELU(1)) dut_b (.clk(clk), .rst(rst), .bus(ib.slave));
    conv_window_mac #(.SHIFT(2), .RELU(0)) dut_c (.clk(clk), .rst(rst), .bus(ic.slave));

    logic bp_mode;
    logic ready_val;
    logic rnd_rdy;

    assign ia.out_ready = bp_mode ? rnd_rdy : ready_val;
    assign ib.w_start   = ia.w_start;
    assign ib.w_valid   = ia.w_valid;
    assign ib.w_data    = ia.w_data;
    assign ib.in_valid  = ia.in_valid;
    assign ib.in_data   = ia.in_data;
    assign ib.out_ready = ia.out_ready;
    assign ic.w_start   = ia.w_start;
    assign ic.w_valid   = ia.w_valid;
    assign ic.w_data    = ia.w_data;
    assign ic.in_valid  = ia.in_valid;
    assign ic.in_data   = ia.in_data;
    assign ic.out_ready = ia.out_ready;

    logic [2:0] ov, ir, bz, wl;
    logic [7:0] od [3];
    assign ov = {ic.out_valid, ib.out_valid, ia.out_valid};
    assign ir = {ic.in_ready,  ib.in_ready,  ia.in_ready};
    assign bz = {ic.busy,      ib.busy,      ia.busy};
    assign wl = {ic.w_loaded,  ib.w_loaded,  ia.w_loaded};
    assign od[0] = ia.out_data;
    assign od[1] = ib.out_data;
    assign od[2] = ic.out_data;

    int n_chk;
    int n_fail;
    logic signed [7:0] wts [9];
    logic [7:0] expq [3][$];
    logic       hold [3];
    logic [7:0] hold_d [3];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) rnd_rdy = ($urandom_range(0, 3) != 0);

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exp, exp);
        end
    endtask

    function automatic logic [7:0] model(input longint acc, input int sh, input bit relu);
        longint s, hi, lo;
        logic [63:0] r;
        s  = acc >>> sh;
        hi = relu ? 255 : 127;
        lo = relu ? 0 : -128;
        if (s > hi) s = hi;
        if (s < lo) s = lo;
        r = s;
        return r[7:0];
    endfunction

    task automatic push_exp(input logic [8:0][7:0] px);
        longint acc;
        acc = 0;
        for (int i = 0; i < 9; i++)
            acc += longint'(wts[i]) * longint'({56'd0, px[i]});
        expq[0].push_back(model(acc, 0, 1'b0));
        expq[1].push_back(model(acc, 0, 1'b1));
        expq[2].push_back(model(acc, 2, 1'b0));
    endtask

    always @(negedge clk) begin
        logic [7:0] e;
        #2;
        for (int i = 0; i < 3; i++) begin
            if (rst) begin
                hold[i] = 1'b0;
            end else begin
                if (hold[i]) begin
                    chk($sformatf("hold_valid_%0d", i), {31'd0, ov[i]}, 1);
                    chk($sformatf("hold_data_%0d", i), {24'd0, od[i]}, {24'd0, hold_d[i]});
                end
                if (ov[i])
                    chk($sformatf("no_overlap_%0d", i), {31'd0, ir[i]}, 0);
                if (ov[i] && ia.out_ready) begin
                    if (expq[i].size() == 0) begin
                        n_chk++;
                        n_fail++;
                        $display("FAIL unexpected_out_%0d: got %0d with no result pending", i, od[i]);
                    end else begin
                        e = expq[i].pop_front();
                        chk($sformatf("result_%0d", i), {24'd0, od[i]}, {24'd0, e});
                    end
                end
                hold[i]   = ov[i] && !ia.out_ready;
                hold_d[i] = od[i];
            end
        end
    end

    task automatic send_px(input logic [7:0] p);
        int n;
        n = 0;
        ia.in_valid = 1'b1;
        ia.in_data  = p;
        #1;
        while (!ia.in_ready && n < 300) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("px_accept_in_time", {31'd0, (n < 300)}, 1);
        @(negedge clk);
        ia.in_valid = 1'b0;
    endtask

    task automatic send_window(input logic [8:0][7:0] px, input bit gaps);
        push_exp(px);
        for (int i = 0; i < 9; i++) begin
            if (gaps) begin
                int g = $urandom_range(0, 2);
                repeat (g) begin
                    ia.w_start = (i > 0) && ($urandom_range(0, 1) == 1);
                    @(negedge clk);
                end
                ia.w_start = 1'b0;
            end
            send_px(px[i]);
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((expq[0].size() != 0 || expq[1].size() != 0 || expq[2].size() != 0 || ov != 3'b000)
               && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk("drain_in_time", {31'd0, (n < 1000)}, 1);
    endtask

    task automatic load_w(input logic [8:0][7:0] w, input bit pre_started);
        if (!pre_started) begin
            ia.w_start = 1'b1;
            @(negedge clk);
            ia.w_start = 1'b0;
        end
        #1;
        chk("loadw_busy", {29'd0, bz}, 7);
        for (int i = 0; i < 9; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                ia.w_valid = 1'b0;
                @(negedge clk);
            end
            ia.w_valid = 1'b1;
            ia.w_data  = w[i];
            wts[i]     = w[i];
            @(negedge clk);
        end
        ia.w_valid = 1'b0;
        #1;
        chk("w_loaded", {29'd0, wl}, 7);
        chk("loadw_done_idle", {29'd0, bz}, 0);
    endtask

    task automatic check_reset();
        chk("rst_out_valid", {29'd0, ov}, 0);
        chk("rst_in_ready", {29'd0, ir}, 0);
        chk("rst_busy", {29'd0, bz}, 0);
        chk("rst_w_loaded", {29'd0, wl}, 0);
        for (int i = 0; i < 3; i++)
            chk($sformatf("rst_out_data_%0d", i), {24'd0, od[i]}, 0);
    endtask

    task automatic no_accept(input string nm, input int cycles);
        ia.in_valid = 1'b1;
        ia.in_data  = 8'd5;
        repeat (cycles) begin
            #1;
            chk(nm, {29'd0, ir}, 0);
            @(negedge clk);
        end
        ia.in_valid = 1'b0;
    endtask

    task automatic direct(input logic [7:0] wv, input logic [7:0] pv,
                          input logic [7:0] ea, input logic [7:0] eb, input logic [7:0] ec);
        logic [8:0][7:0] w, p;
        for (int i = 0; i < 9; i++) begin
            w[i] = wv;
            p[i] = pv;
        end
        drain();
        load_w(w, 1'b0);
        send_window(p, 1'b0);
        #1;
        chk("dir_valid", {29'd0, ov}, 7);
        chk("dir_plain", {24'd0, od[0]}, {24'd0, ea});
        chk("dir_relu", {24'd0, od[1]}, {24'd0, eb});
        chk("dir_shift", {24'd0, od[2]}, {24'd0, ec});
        @(negedge clk);
    endtask

    initial begin
        logic [8:0][7:0] w, p;
        n_chk = 0;
        n_fail = 0;
        rst = 1'b1;
        bp_mode = 1'b0;
        ready_val = 1'b1;
        ia.w_start = 1'b0;
        ia.w_valid = 1'b0;
        ia.w_data = '0;
        ia.in_valid = 1'b0;
        ia.in_data = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        check_reset();
        @(negedge clk);
        no_accept("unloaded_no_accept", 3);

        // ones kernel, pixels 1..9: 45, latency and single-cycle result with ready high
        for (int i = 0; i < 9; i++) begin
            w[i] = 8'd1;
            p[i] = 8'(i + 1);
        end
        load_w(w, 1'b0);
        @(negedge clk);
        send_window(p, 1'b0);
        #1;
        chk("lat_valid", {29'd0, ov}, 7);
        chk("sum45_plain", {24'd0, od[0]}, 45);
        chk("sum45_relu", {24'd0, od[1]}, 45);
        chk("sum45_shift", {24'd0, od[2]}, 11);
        @(negedge clk);
        #1;
        chk("valid_drop", {29'd0, ov}, 0);
        @(negedge clk);

        direct(8'd127, 8'd255, 8'h7f, 8'hff, 8'h7f);
        direct(8'h80, 8'd255, 8'h80, 8'h00, 8'h80);
        direct(8'd2, 8'd10, 8'h7f, 8'd180, 8'd45);

        // backpressure: result held, no pixel taken, w_start ignored in OUT
        drain();
        ready_val = 1'b0;
        for (int i = 0; i < 9; i++) p[i] = 8'($urandom_range(0, 255));
        send_window(p, 1'b0);
        #1;
        chk("bp_valid", {29'd0, ov}, 7);
        ia.in_valid = 1'b1;
        ia.in_data  = 8'd99;
        for (int c = 0; c < 5; c++) begin
            ia.w_start = (c == 2);
            @(negedge clk);
            #1;
            chk("bp_in_ready", {29'd0, ir}, 0);
            chk("bp_still_out", {29'd0, ov}, 7);
        end
        ia.w_start  = 1'b0;
        ia.in_valid = 1'b0;
        ready_val   = 1'b1;
        drain();
        for (int i = 0; i < 9; i++) p[i] = 8'($urandom_range(0, 255));
        send_window(p, 1'b0);
        drain();

        // random kernels, gaps, w_start pulses in ACC, random backpressure
        bp_mode = 1'b1;
        for (int k = 0; k < 4; k++) begin
            drain();
            for (int i = 0; i < 9; i++)
                w[i] = (k == 0) ? ((i % 2 == 0) ? 8'h80 : 8'h7f) : 8'($urandom_range(0, 255));
            load_w(w, 1'b0);
            for (int j = 0; j < 3; j++) begin
                for (int i = 0; i < 9; i++) p[i] = 8'($urandom_range(0, 255));
                send_window(p, 1'b1);
            end
        end
        drain();
        bp_mode = 1'b0;

        // w_start and in_valid together in IDLE: load wins, pixel not consumed
        @(negedge clk);
        ia.w_start  = 1'b1;
        ia.in_valid = 1'b1;
        ia.in_data  = 8'd77;
        #1;
        chk("ws_prio_in_ready", {29'd0, ir}, 0);
        @(negedge clk);
        ia.w_start  = 1'b0;
        ia.in_valid = 1'b0;
        for (int i = 0; i < 9; i++) w[i] = 8'($urandom_range(0, 255));
        load_w(w, 1'b1);
        for (int i = 0; i < 9; i++) p[i] = 8'($urandom_range(0, 255));
        send_window(p, 1'b0);
        drain();

        // reset after the 4th tap aborts the window and the kernel
        for (int i = 0; i < 4; i++) send_px(8'($urandom_range(0, 255)));
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_reset();
        @(negedge clk);
        no_accept("post_rst_no_accept", 2);
        for (int i = 0; i < 9; i++) w[i] = 8'($urandom_range(0, 255));
        load_w(w, 1'b0);
        for (int i = 0; i < 9; i++) p[i] = 8'($urandom_range(0, 255));
        send_window(p, 1'b0);
        drain();

        chk("queue_a_empty", expq[0].size(), 0);
        chk("queue_b_empty", expq[1].size(), 0);
        chk("queue_c_empty", expq[2].size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/conv_window_mac.md
Name: conv_window_mac

Overview:
- Parametrised successor to the single-stage computation engine: a streaming multiply-accumulate unit for one output pixel of a K×K convolution.
- Holds a loadable K×K signed weight kernel and accepts one unsigned input-feature-map pixel per beat over a valid/ready handshake.
- Accumulates K*K products, then applies shift, optional ReLU and saturation, and presents one output-feature-map value with backpressure.
- Sits between the window/line-buffer fetch logic and the output feature-map writer.

Parameters:
- DATA_W, 8, pixel width (unsigned input) and weight width (signed two's complement)
- K, 3, kernel dimension; window holds K*K taps
- ACC_W, 24, signed accumulator width; must be >= 2*DATA_W+1+ceil(log2(K*K))
- OUT_W, 8, output width
- SHIFT, 0, arithmetic right shift applied to the accumulator before clamping
- RELU, 0, 1 = clamp negatives to 0; 0 = signed output range

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- w_start  in  1  pulse: begin a kernel load (honoured only in IDLE)
- w_valid  in  1  weight beat valid (LOADW only)
- w_data  in  DATA_W  signed weight; tap order row-major, index 0..K*K-1
- w_loaded  out  1  kernel loaded since reset
- in_valid  in  1  pixel beat valid
- in_ready  out  1  pixel accepted when in_valid && in_ready
- in_data  in  DATA_W  unsigned pixel, row-major window order
- out_valid  out  1  result valid
- out_ready  in  1  downstream accept
- out_data  out  OUT_W  result; signed if RELU=0, unsigned if RELU=1
- busy  out  1  state != IDLE

Behaviour:
- Reset: state=IDLE, acc=0, tap_cnt=0, w_loaded=0, out_valid=0, out_data=0, in_ready=0, busy=0. Weight registers are cleared to 0.
- Reset mid-operation aborts any load or accumulation in progress. The partial kernel is discarded and w_loaded=0.
- FSM states: IDLE, LOADW, ACC, OUT.
- IDLE:
  - w_start=1 -> LOADW, tap_cnt=0.
  - Else if w_loaded && in_valid -> the pixel is accepted this cycle (in_ready=1 in IDLE iff w_loaded && !w_start), acc=product(0), tap_cnt=1, next state ACC.
  - If w_start and in_valid are both high, w_start wins and the pixel is not accepted.
- LOADW:
  - Each w_valid beat writes w_data to weight[tap_cnt] and increments tap_cnt.
  - On the beat with tap_cnt==K*K-1 -> IDLE, w_loaded=1, tap_cnt=0.
  - in_ready=0 throughout. w_start is ignored.
- ACC:
  - in_ready=1. Each accepted beat: acc += sign_extend(weight[tap_cnt]) * zero_extend(in_data), tap_cnt++.
  - The beat at tap_cnt==K*K-1 -> OUT. In that same edge, out_data is registered and out_valid=1.
  - Gaps (in_valid=0) hold all state.
- Latency: out_valid rises on the clock edge that accepts the last tap, i.e. it is visible in the cycle after the last handshake.
- Result computation:
  - s = acc >>> SHIFT (arithmetic shift).
  - RELU=1: out = s<0 ? 0 : min(s, 2^OUT_W-1).
  - RELU=0: out = clamp(s, -2^(OUT_W-1), 2^(OUT_W-1)-1).
- OUT:
  - out_valid=1. out_data is stable until out_valid && out_ready.
  - in_ready=0 (no overlap with the next window).
  - On the handshake -> IDLE, acc=0, tap_cnt=0, out_valid=0.
  - out_ready held high gives one idle cycle between windows.
- w_start in ACC or OUT is ignored, and the kernel is unchanged.
- in_valid before w_loaded is never accepted.
- Weights persist across windows until the next load.

Test Plan:
- Load weights all 1; stream pixels 1..9 with out_ready=1 -> out_data=45 one cycle after the 9th handshake, then out_valid drops.
- Load weights all 127; pixels all 255; RELU=0, SHIFT=0 -> acc=291465, out_data=127 (saturated). Repeat with weights all -128 -> out_data=-128; with RELU=1 -> out_data=0.
- SHIFT=2, weights all 2, pixels all 10 -> acc=180, out_data=45.
- Hold out_ready=0 for 5 cycles after the result -> out_valid and out_data stable, in_ready=0, an offered next pixel is not accepted. Raise out_ready -> handshake, then the next window result is correct (acc cleared).
- Insert random in_valid gaps, and pulse w_start during ACC -> result identical to the gap-free run, kernel unchanged. In IDLE, w_start with in_valid both high -> LOADW entered and no pixel consumed.
- Assert rst after the 4th tap -> all outputs at reset values and w_loaded=0. A pixel offered before reload is not accepted. Reload and a full window give the correct result.
